// File: rtl/comp_layer_ctrl_if.sv
// Handshake bundle for the comp-layer sequencer: serial score stream in, class result out.
// The slave modport is the controller's view; master is the upstream/downstream side.
interface comp_layer_ctrl_if #(
    parameter int DATA_LEN = 16
) ();
    logic                s_valid;
    logic                s_ready;
    logic [DATA_LEN-1:0] s_data;
    logic                m_valid;
    logic                m_ready;
    logic [3:0]          m_class;
    logic                m_err;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_class, m_err
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_class, m_err
    );
endinterface

// File: rtl/comp_layer_ctrl.sv
// Sequencer for the 12-input argmax comparator tree: packs a serial score frame, drives the
// tree load window for its pipeline depth, then presents the winning class under valid/ready.
module comp_layer_ctrl #(
    parameter int DATA_LEN = 16,
    parameter int N_CLASS  = 12,
    parameter int TREE_LAT = 4,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    comp_layer_ctrl_if.slave             bus,
    output logic                         comp_load,
    output logic [N_CLASS*DATA_LEN-1:0]  comp_d,
    input  logic [3:0]                   comp_q,
    output logic                         busy,
    output logic [CNT_W-1:0]             frame_cnt
);
    localparam int IDX_W = $clog2(N_CLASS);
    localparam int RUN_W = (TREE_LAT > 1) ? $clog2(TREE_LAT) : 1;

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_CAPT,
        S_OUT
    } state_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              wr_idx_q, wr_idx_d;
    logic [RUN_W-1:0]              run_cnt_q, run_cnt_d;
    logic [N_CLASS*DATA_LEN-1:0]   comp_d_q;
    logic                          m_valid_q, m_valid_d;
    logic [3:0]                    m_class_q, m_class_d;
    logic                          m_err_q, m_err_d;
    logic [CNT_W-1:0]              frame_cnt_q, frame_cnt_d;
    logic                          wr_en;
    logic                          s_ready;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        run_cnt_d   = run_cnt_q;
        m_valid_d   = m_valid_q;
        m_class_d   = m_class_q;
        m_err_d     = m_err_q;
        frame_cnt_d = frame_cnt_q;
        wr_en       = 1'b0;
        s_ready     = (state_q == S_FILL);
        comp_load   = (state_q == S_RUN);

        unique case (state_q)
            S_FILL: begin
                if (bus.s_valid) begin
                    wr_en = 1'b1;
                    if (wr_idx_q == IDX_W'(N_CLASS - 1)) begin
                        state_d   = S_RUN;
                        wr_idx_d  = '0;
                        run_cnt_d = '0;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (run_cnt_q == RUN_W'(TREE_LAT - 1)) begin
                    state_d = S_CAPT;
                end else begin
                    run_cnt_d = run_cnt_q + RUN_W'(1);
                end
            end
            S_CAPT: begin
                m_class_d = comp_q;
                m_err_d   = (comp_q == 4'd0) || (comp_q > 4'(N_CLASS));
                m_valid_d = 1'b1;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (bus.m_ready) begin
                    m_valid_d   = 1'b0;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    state_d     = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase

        // Flush overrides everything, including a beat or a result handshake in the same cycle.
        if (flush) begin
            state_d     = S_FILL;
            wr_idx_d    = '0;
            run_cnt_d   = '0;
            m_valid_d   = 1'b0;
            m_class_d   = m_class_q;
            m_err_d     = m_err_q;
            frame_cnt_d = frame_cnt_q;
            wr_en       = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            wr_idx_q    <= '0;
            run_cnt_q   <= '0;
            m_valid_q   <= 1'b0;
            m_class_q   <= '0;
            m_err_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            run_cnt_q   <= run_cnt_d;
            m_valid_q   <= m_valid_d;
            m_class_q   <= m_class_d;
            m_err_q     <= m_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // NOTE: the score buffer is reset so the tree never sees X; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_d_q <= '0;
        end else if (wr_en) begin
            comp_d_q[int'(wr_idx_q)*DATA_LEN +: DATA_LEN] <= bus.s_data;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_class = m_class_q;
    assign bus.m_err   = m_err_q;
    assign comp_d      = comp_d_q;
    assign frame_cnt   = frame_cnt_q;
    assign busy        = (state_q != S_FILL) || (wr_idx_q != '0);
endmodule

// File: tb/tb_comp_layer_ctrl.sv
// Self-checking bench for comp_layer_ctrl: a behavioural 4-stage argmax tree drives comp_q,
// a vector table plus random frames are compared against the bench's own expected results.
module tb_comp_layer_ctrl;
    localparam int DL = 16;
    localparam int NC = 12;

    typedef logic signed [DL-1:0] score_t;
    typedef score_t score_arr_t [NC];
    typedef struct {
        int         win;
        score_t     win_val;
        score_t     base;
        int         gap;
        int         stall;
        bit         f_en;
        logic [3:0] f_q;
        logic [3:0] exp_cls;
        bit         exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    comp_layer_ctrl_if #(.DATA_LEN(DL)) bus ();
    logic             comp_load;
    logic [NC*DL-1:0] comp_d;
    logic [3:0]       comp_q;
    logic             busy;
    logic [15:0]      frame_cnt;

    comp_layer_ctrl #(.DATA_LEN(DL), .N_CLASS(NC), .TREE_LAT(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .comp_load (comp_load),
        .comp_d    (comp_d),
        .comp_q    (comp_q),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    int         vec_cnt = 0;
    int         miss_cnt = 0;
    int         exp_cnt = 0;
    int         cyc = 0;
    int         load_total = 0;
    bit         force_en = 1'b0;
    logic [3:0] force_q = 4'd0;
    logic [3:0] pipe [4];

    // First (lowest-index) maximum wins; returns a 1-based class index.
    function automatic logic [3:0] argmax_vec(input logic [NC*DL-1:0] v);
        int     best = 0;
        score_t bs = score_t'(v[DL-1:0]);
        for (int k = 1; k < NC; k++) begin
            score_t s = score_t'(v[k*DL +: DL]);
            if (s > bs) begin
                bs   = s;
                best = k;
            end
        end
        return 4'(best + 1);
    endfunction

    function automatic logic [NC*DL-1:0] pack(input score_arr_t a);
        logic [NC*DL-1:0] v = '0;
        for (int k = 0; k < NC; k++) v[k*DL +: DL] = a[k];
        return v;
    endfunction

    // Tree model: four registered stages that advance only while load is high.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (comp_load) begin
            load_total <= load_total + 1;
            pipe[0] <= argmax_vec(comp_d);
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign comp_q = force_en ? force_q : pipe[3];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input score_t d, input int max_gap);
        int n = 0;
        bus.s_valid = 1'b0;
        repeat ($urandom_range(max_gap)) step();
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (!bus.s_ready && n < 50) begin
            step();
            n++;
        end
        if (!bus.s_ready) begin
            check("beat_accept_timeout", 32'(bus.s_ready), 32'd1);
        end else begin
            step();
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic send_scores(input score_arr_t sc, input int gap);
        for (int k = 0; k < NC; k++) send_beat(sc[k], gap);
    endtask

    function automatic score_arr_t make_frame(input int win, input score_t wv, input score_t base);
        score_arr_t sc;
        for (int k = 0; k < NC; k++) sc[k] = base;
        sc[win-1] = wv;
        return sc;
    endfunction

    // One complete frame: latency checks, optional output stall, then the handshake.
    task automatic run_frame(input score_arr_t sc, input int gap, input int stall, input bit f_en,
                             input logic [3:0] f_q, input logic [3:0] ecls, input bit eerr,
                             output int mv_cyc);
        int base_loads;
        force_en   = f_en;
        force_q    = f_q;
        base_loads = load_total;
        send_scores(sc, gap);
        check("run_load_t1", 32'(comp_load), 32'd1);
        check("run_sready_t1", 32'(bus.s_ready), 32'd0);
        check("run_busy_t1", 32'(busy), 32'd1);
        repeat (4) step();
        check("capt_load_t5", 32'(comp_load), 32'd0);
        check("capt_mvalid_t5", 32'(bus.m_valid), 32'd0);
        step();
        check("mvalid_t6", 32'(bus.m_valid), 32'd1);
        mv_cyc = cyc;
        for (int i = 0; i < stall; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = DL'($urandom);
            check("stall_mvalid", 32'(bus.m_valid), 32'd1);
            check("stall_class", 32'(bus.m_class), 32'(ecls));
            check("stall_sready", 32'(bus.s_ready), 32'd0);
            step();
        end
        bus.s_valid = 1'b0;
        check("m_class", 32'(bus.m_class), 32'(ecls));
        check("m_err", 32'(bus.m_err), 32'(eerr));
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        exp_cnt++;
        check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt[15:0]));
        check("post_mvalid", 32'(bus.m_valid), 32'd0);
        check("post_sready", 32'(bus.s_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
        check("load_cycles", 32'(load_total - base_loads), 32'd4);
        force_en = 1'b0;
    endtask

    vec_t tbl [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        score_arr_t sc;
        int         mv, last_mv;
        logic [3:0] ecls;

        tbl[0] = '{7,  16'sd100,    -16'sd5,     0, 0,  1'b0, 4'd0,  4'd7,  1'b0};
        tbl[1] = '{12, 16'sh7FFF,   16'sh7FFE,   3, 10, 1'b0, 4'd0,  4'd12, 1'b0};
        tbl[2] = '{1,  -16'sd1,     -16'sd32768, 0, 0,  1'b0, 4'd0,  4'd1,  1'b0};
        tbl[3] = '{5,  16'sd0,      -16'sd1,     1, 2,  1'b0, 4'd0,  4'd5,  1'b0};
        tbl[4] = '{5,  16'sd10,     16'sd0,      0, 0,  1'b1, 4'd0,  4'd0,  1'b1};
        tbl[5] = '{5,  16'sd10,     16'sd0,      0, 1,  1'b1, 4'd13, 4'd13, 1'b1};
        tbl[6] = '{2,  16'sd10,     16'sd0,      0, 0,  1'b1, 4'd15, 4'd15, 1'b1};
        tbl[7] = '{4,  16'sd10,     16'sd0,      0, 0,  1'b1, 4'd12, 4'd12, 1'b0};
        tbl[8] = '{9,  16'sd10,     16'sd0,      0, 0,  1'b1, 4'd1,  4'd1,  1'b0};
        tbl[9] = '{12, -16'sd32767, -16'sd32768, 2, 1,  1'b0, 4'd0,  4'd12, 1'b0};

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_sready", 32'(bus.s_ready), 32'd1);
        check("rst_load", 32'(comp_load), 32'd0);
        check("rst_mvalid", 32'(bus.m_valid), 32'd0);
        check("rst_mclass", 32'(bus.m_class), 32'd0);
        check("rst_merr", 32'(bus.m_err), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_comp_d_zero", 32'(comp_d == '0), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        // Vector table: plain winners, max-value boundary with stall, out-of-range comp_q
        for (int i = 0; i < 10; i++) begin
            sc = make_frame(tbl[i].win, tbl[i].win_val, tbl[i].base);
            run_frame(sc, tbl[i].gap, tbl[i].stall, tbl[i].f_en, tbl[i].f_q,
                      tbl[i].exp_cls, tbl[i].exp_err, mv);
        end

        // Back-to-back frames: 18-cycle period
        begin
            int wins [3] = '{1, 12, 5};
            for (int i = 0; i < 3; i++) begin
                sc = make_frame(wins[i], 16'sd77, -16'sd100);
                run_frame(sc, 0, 0, 1'b0, 4'd0, 4'(wins[i]), 1'b0, mv);
                if (i > 0) check("b2b_period", 32'(mv - last_mv), 32'd18);
                last_mv = mv;
            end
        end

        // Flush after 6 beats, with a beat presented in the flush cycle
        for (int k = 0; k < 6; k++) send_beat(16'sd1000, 0);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'sd1000;
        flush       = 1'b1;
        step();
        flush       = 1'b0;
        bus.s_valid = 1'b0;
        check("flush_fill_busy", 32'(busy), 32'd0);
        check("flush_fill_sready", 32'(bus.s_ready), 32'd1);
        check("flush_fill_cnt", 32'(frame_cnt), 32'(exp_cnt[15:0]));
        sc = make_frame(3, 16'sd50, 16'sd0);
        run_frame(sc, 0, 0, 1'b0, 4'd0, 4'd3, 1'b0, mv);

        // Flush during RUN
        sc = make_frame(9, 16'sd300, 16'sd1);
        send_scores(sc, 0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_run_mvalid", 32'(bus.m_valid), 32'd0);
        check("flush_run_load", 32'(comp_load), 32'd0);
        check("flush_run_sready", 32'(bus.s_ready), 32'd1);
        check("flush_run_busy", 32'(busy), 32'd0);
        repeat (6) step();
        check("flush_run_no_result", 32'(bus.m_valid), 32'd0);
        sc = make_frame(10, 16'sd5, -16'sd5);
        run_frame(sc, 1, 0, 1'b0, 4'd0, 4'd10, 1'b0, mv);

        // Flush coincident with the output handshake: no count
        sc = make_frame(2, 16'sd9, 16'sd8);
        send_scores(sc, 0);
        repeat (5) step();
        check("flush_hs_mvalid_pre", 32'(bus.m_valid), 32'd1);
        bus.m_ready = 1'b1;
        flush       = 1'b1;
        step();
        flush       = 1'b0;
        bus.m_ready = 1'b0;
        check("flush_hs_cnt", 32'(frame_cnt), 32'(exp_cnt[15:0]));
        check("flush_hs_mvalid", 32'(bus.m_valid), 32'd0);
        check("flush_hs_sready", 32'(bus.s_ready), 32'd1);

        // Async reset pulse during OUT
        sc = make_frame(6, 16'sd44, 16'sd43);
        send_scores(sc, 0);
        repeat (5) step();
        check("rst_out_mvalid_pre", 32'(bus.m_valid), 32'd1);
        rst_n = 1'b0;
        #2;
        check("rst_out_mvalid", 32'(bus.m_valid), 32'd0);
        check("rst_out_cnt", 32'(frame_cnt), 32'd0);
        check("rst_out_sready", 32'(bus.s_ready), 32'd1);
        check("rst_out_comp_d", 32'(comp_d == '0), 32'd1);
        rst_n   = 1'b1;
        exp_cnt = 0;
        step();
        sc = make_frame(11, 16'sd1, 16'sd0);
        run_frame(sc, 0, 0, 1'b0, 4'd0, 4'd11, 1'b0, mv);

        // Random frames against the argmax reference
        for (int f = 0; f < 16; f++) begin
            for (int k = 0; k < NC; k++) sc[k] = score_t'($urandom);
            ecls = argmax_vec(pack(sc));
            run_frame(sc, 3, $urandom_range(4), 1'b0, 4'd0, ecls, 1'b0, mv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
